// File: rtl/evo_pkg.sv
// ----------------------------------------------------------------------------
// evo_pkg
// Shared definitions for the evolvable-hardware fitness path.
//   - Default candidate geometry (EVO_N_IN inputs, EVO_N_OUT outputs), which is
//     also used by the candidate generator so both sides agree on the netlist
//     shape.
//   - Derived sizes: vector count, truth-table width, score width.
//   - Evaluator FSM state encoding.
// ----------------------------------------------------------------------------
package evo_pkg;

    localparam int EVO_N_IN      = 4;
    localparam int EVO_N_OUT     = 4;
    localparam int EVO_VEC_COUNT = 2 ** EVO_N_IN;
    localparam int EVO_TT_W      = EVO_N_OUT * EVO_VEC_COUNT;
    localparam int EVO_SCORE_W   = $clog2(EVO_TT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } eval_state_t;

endpackage

// File: rtl/vector_sequencer.sv
// ----------------------------------------------------------------------------
// vector_sequencer
// Walks the candidate input vectors 0 .. 2**N_IN-1, holding each one for
// SETTLE_CYCLES clocks, and flags the cycle in which the candidate outputs
// should be sampled.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   load    in   restart at vector 0 with a full settle window
//   en      in   advance the settle counter (evaluation running)
//   vec     out  current input vector (registered)
//   sample  out  settle window of the current vector has elapsed
//   last    out  sample strobe for the final vector
// ----------------------------------------------------------------------------
module vector_sequencer
    import evo_pkg::*;
#(
    parameter int N_IN          = EVO_N_IN,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            en,
    output logic [N_IN-1:0] vec,
    output logic            sample,
    output logic            last
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign sample = en && (cnt == '0);
    assign last   = sample && (vec == {N_IN{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec <= '0;
            cnt <= '0;
        end else if (load) begin
            vec <= '0;
            cnt <= RELOAD;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= RELOAD;
                // Final vector stays on the bus; only start/reset rewind it.
                if (!last) begin
                    vec <= vec + 1'b1;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fitness_evaluator.sv
// ----------------------------------------------------------------------------
// fitness_evaluator
// Scores one combinational candidate against a target truth table: every
// input vector is driven onto the candidate, held for SETTLE_CYCLES clocks,
// then the candidate outputs are compared bit by bit with the latched target.
// The number of matching bits is reported as the fitness score.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin evaluation (honoured in IDLE or DONE only)
//   target     in   truth table, bit [v*N_OUT+o] = output o for vector v
//   dut_in     out  vector driven onto the candidate inputs
//   dut_out    in   candidate outputs
//   busy       out  evaluation in progress
//   done       out  one-cycle pulse, score valid
//   score      out  matching-bit count, held until the next accepted start
// Optional (macro FIRST_FAIL_EN):
//   fail_valid out  some vector has mismatched
//   fail_vec   out  first vector that mismatched
// ----------------------------------------------------------------------------
module fitness_evaluator
    import evo_pkg::*;
#(
    parameter int N_IN          = EVO_N_IN,
    parameter int N_OUT         = EVO_N_OUT,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic [N_OUT*(2**N_IN)-1:0]               target,
    output logic [N_IN-1:0]                          dut_in,
    input  logic [N_OUT-1:0]                         dut_out,
    output logic                                     busy,
    output logic                                     done,
    output logic [$clog2(N_OUT*(2**N_IN)+1)-1:0]     score
`ifdef FIRST_FAIL_EN
    ,
    output logic                                     fail_valid,
    output logic [N_IN-1:0]                          fail_vec
`endif
);

    localparam int VEC_COUNT = 2 ** N_IN;
    localparam int TT_W      = N_OUT * VEC_COUNT;
    localparam int SCORE_W   = $clog2(TT_W + 1);
    localparam int MATCH_W   = $clog2(N_OUT + 1);

    eval_state_t        state;
    logic [TT_W-1:0]    tt_q;
    logic [N_IN-1:0]    vec;
    logic               accept;
    logic               sample;
    logic               last;
    logic [N_OUT-1:0]   exp_bits;
    logic [MATCH_W-1:0] match_cnt;
    logic               all_match;

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    vector_sequencer #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .en     (state == S_RUN),
        .vec    (vec),
        .sample (sample),
        .last   (last)
    );

    assign dut_in = vec;

    // Target is only data: latched on accept, never needs a reset value.
    always_ff @(posedge clk) begin
        if (accept) begin
            tt_q <= target;
        end
    end

    assign exp_bits = tt_q[int'(vec)*N_OUT +: N_OUT];

    // Case equality so an X/Z candidate output never counts as a match.
    always_comb begin
        match_cnt = '0;
        for (int o = 0; o < N_OUT; o++) begin
            if (dut_out[o] === exp_bits[o]) begin
                match_cnt = match_cnt + MATCH_W'(1);
            end
        end
    end

    assign all_match = (match_cnt == MATCH_W'(N_OUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            score <= '0;
`ifdef FIRST_FAIL_EN
            fail_valid <= 1'b0;
            fail_vec   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        score <= '0;
`ifdef FIRST_FAIL_EN
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (sample) begin
                        score <= score + SCORE_W'(match_cnt);
`ifdef FIRST_FAIL_EN
                        if (!all_match && !fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= vec;
                        end
`endif
                        if (last) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef FIRST_FAIL_EN
    // The mismatch summary only feeds the first-fail capture.
    logic unused_match;
    assign unused_match = all_match;
`endif

endmodule

// File: tb/tb_fitness_evaluator.sv
module tb_fitness_evaluator;

    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int VECS  = 16;
    localparam int SETTLE = 8;
    localparam int LIMIT = 300;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic [63:0] target;

    logic [3:0]  dut_in, dut_out;
    logic        busy, done;
    logic [6:0]  score;

    logic [3:0]  dut_in2, dut_in4;
    logic [3:0]  a1, a2, a3, b1, b2, b3;
    logic        busy2, done2, busy4, done4;
    logic [6:0]  score2, score4;

    logic [3:0]  lut [16];

    int n_cmp;
    int n_err;

`ifdef FIRST_FAIL_EN
    logic       fail_valid, fail_valid2, fail_valid4;
    logic [3:0] fail_vec, fail_vec2, fail_vec4;
`endif

    fitness_evaluator #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target(target),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .score(score)
`ifdef FIRST_FAIL_EN
        , .fail_valid(fail_valid), .fail_vec(fail_vec)
`endif
    );

    fitness_evaluator #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .target(target),
        .dut_in(dut_in2), .dut_out(a3), .busy(busy2), .done(done2), .score(score2)
`ifdef FIRST_FAIL_EN
        , .fail_valid(fail_valid2), .fail_vec(fail_vec2)
`endif
    );

    fitness_evaluator #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .start(start2), .target(target),
        .dut_in(dut_in4), .dut_out(b3), .busy(busy4), .done(done4), .score(score4)
`ifdef FIRST_FAIL_EN
        , .fail_valid(fail_valid4), .fail_vec(fail_vec4)
`endif
    );

    // Candidate for the main instance: zero-delay lookup table.
    assign dut_out = lut[dut_in];

    // Candidates for the slow instances: identity with a 3-clock delay.
    always @(posedge clk) begin
        a1 <= dut_in2; a2 <= a1; a3 <= a2;
        b1 <= dut_in4; b2 <= b1; b3 <= b2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] identity_tt();
        logic [63:0] t;
        logic [3:0]  vv;
        t = '0;
        for (int v = 0; v < VECS; v++) begin
            vv = 4'(v);
            for (int o = 0; o < N_OUT; o++) t[v*N_OUT+o] = vv[o];
        end
        return t;
    endfunction

    // Fitness = number of truth-table bits the candidate reproduces.
    function automatic int model_score(input logic [63:0] tt);
        int s;
        logic [3:0] y;
        s = 0;
        for (int v = 0; v < VECS; v++) begin
            y = lut[v];
            for (int o = 0; o < N_OUT; o++) if (tt[v*N_OUT+o] == y[o]) s++;
        end
        return s;
    endfunction

    function automatic int model_first_fail(input logic [63:0] tt);
        for (int v = 0; v < VECS; v++)
            if (tt[v*N_OUT +: N_OUT] != lut[v]) return v;
        return -1;
    endfunction

    task automatic set_identity_lut();
        for (int v = 0; v < VECS; v++) lut[v] = 4'(v);
    endtask

    // One evaluation on the main instance. Cycle k=1 is the first cycle after
    // the accepting edge; done is expected in cycle VECS*SETTLE+1.
    task automatic run_eval(input string tag, input logic [63:0] tt, input bit pre,
                            input int restart_at, input int tchange_at,
                            input bit chain, input logic [63:0] next_tt);
        int exp_s;
        int k;
        bit got_done;
`ifdef FIRST_FAIL_EN
        int ffv;
`endif
        exp_s = model_score(tt);
        if (!pre) begin
            @(negedge clk);
            target = tt;
            start  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_score_clr"}, score, 0);
        k = 1;
        got_done = 1'b0;
        while (k <= LIMIT) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            check({tag, "_dut_in"}, dut_in, (k - 1) / SETTLE);
            check({tag, "_busy_run"}, busy, 1);
            start = (k == restart_at);
            if (k == tchange_at) target = {$urandom, $urandom};
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_latency"}, k, VECS * SETTLE + 1);
        check({tag, "_score"}, score, exp_s);
        check({tag, "_busy_done"}, busy, 0);
`ifdef FIRST_FAIL_EN
        ffv = model_first_fail(tt);
        check({tag, "_fail_valid"}, fail_valid, (ffv >= 0) ? 1 : 0);
        if (ffv >= 0) check({tag, "_fail_vec"}, fail_vec, ffv);
`endif
        if (chain) begin
            target = next_tt;
            start  = 1'b1;
        end else begin
            @(negedge clk);
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_score_hold"}, score, exp_s);
        end
    endtask

    initial begin
        logic [63:0] id_tt;
        logic [63:0] t;
        int k, k2, k4, ndone;
        logic [6:0] sc2, sc4;

        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        target = '0;
        set_identity_lut();
        id_tt = identity_tt();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_score", score, 0);
        check("rst_dut_in", dut_in, 0);
`ifdef FIRST_FAIL_EN
        check("rst_fail_valid", fail_valid, 0);
`endif
        rst_n = 1'b1;

        run_eval("identity", id_tt, 0, 0, 0, 0, '0);
        run_eval("inverse", ~id_tt, 0, 0, 0, 0, '0);
        t = id_tt;
        t[4*9+2] = ~t[4*9+2];
        run_eval("flip9", t, 0, 0, 0, 0, '0);
        run_eval("restart_ign", id_tt, 0, 5 * SETTLE + 1, 0, 0, '0);
        run_eval("tgt_change", id_tt, 0, 0, 60, 0, '0);
        run_eval("chain_a", id_tt, 0, 0, 0, 1, {$urandom, $urandom});
        run_eval("chain_b", target, 1, 0, 0, 0, '0);

        for (int r = 0; r < 5; r++) begin
            for (int v = 0; v < VECS; v++) lut[v] = 4'($urandom_range(0, 15));
            run_eval("random", {$urandom, $urandom}, 0, 0, 0, 0, '0);
        end
        set_identity_lut();

        // Reset while vector 7 is on the bus abandons the run.
        @(negedge clk);
        target = id_tt;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7 * SETTLE + 2) @(negedge clk);
        check("midrst_vec7", dut_in, 7);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_score", score, 0);
        check("midrst_dut_in", dut_in, 0);
        check("midrst_done", done, 0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (VECS * SETTLE + 10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);

        // Slow candidate: settle window of 2 is too short, 4 is enough.
        @(negedge clk);
        target = id_tt;
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        k = 1; k2 = 0; k4 = 0; sc2 = '0; sc4 = '0;
        while (k <= LIMIT && (k2 == 0 || k4 == 0)) begin
            if (done2 && k2 == 0) begin k2 = k; sc2 = score2; end
            if (done4 && k4 == 0) begin k4 = k; sc4 = score4; end
            @(negedge clk);
            k++;
        end
        check("s2_latency", k2, VECS * 2 + 1);
        check("s4_latency", k4, VECS * 4 + 1);
        check("s2_short_settle", (sc2 < 7'd64) ? 1 : 0, 1);
        check("s4_score", sc4, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
